// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   Bundle of every signal between the requesters, the arbiter and the
//   single-port data RAM.
//
//   Requester side (one slot per channel c, packed c*W +: W):
//     req      request, held until granted
//     wr       1 = write, 0 = read
//     addr     NCH*AW request address
//     data_wr  NCH*DW write data
//     gnt      one-hot grant, combinational
//     rvalid   one-hot read-return strobe
//     data_rd  shared read data, valid with rvalid
//   RAM side:
//     ram_ce / ram_rd / ram_wr   registered command strobes
//     ram_addr, ram_data_wr      registered command address / write data
//     ram_data_rd                RAM read data, one cycle after a sampled read
//
//   modport slave  : the arbiter
//   modport master : everything around it (requesters plus RAM)
interface ram_port_arbiter_if #(
  parameter int NCH = 3,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    wr;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] data_wr;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    rvalid;
  logic [DW-1:0]     data_rd;

  logic              ram_ce;
  logic              ram_rd;
  logic              ram_wr;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_data_wr;
  logic [DW-1:0]     ram_data_rd;

  modport slave (
    input  req, wr, addr, data_wr, ram_data_rd,
    output gnt, rvalid, data_rd, ram_ce, ram_rd, ram_wr, ram_addr, ram_data_wr
  );

  modport master (
    output req, wr, addr, data_wr, ram_data_rd,
    input  gnt, rvalid, data_rd, ram_ce, ram_rd, ram_wr, ram_addr, ram_data_wr
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one synchronous single-port data RAM among NCH requesters.
//   One request is accepted per cycle (req & gnt). The accepted command is
//   registered toward the RAM; reads carry a channel tag through a 2-stage
//   pipeline so the RAM data returns to the requester that asked for it,
//   two cycles after the grant.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   ram_port_arbiter_if.slave (requester handshake + RAM command/data)
//
//   Build option:
//     RAM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                            undefined -> round-robin (default)
module ram_port_arbiter #(
  parameter int NCH = 3,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input logic              clk,
  input logic              rst,
  ram_port_arbiter_if.slave bus
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          lo_found;
  logic [IW-1:0] lo_idx;
  logic [IW-1:0] sel_idx;
  logic          accept;

  logic          cmd_ce;
  logic          cmd_rd;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data_wr;

  logic          tag1_v;
  logic [IW-1:0] tag1_idx;
  logic          tag2_v;
  logic [IW-1:0] tag2_idx;

  // Lowest-index requester; this is the whole arbiter in fixed-priority
  // builds and the wrap-around half of the round-robin search otherwise.
  always_comb begin
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!lo_found && bus.req[c]) begin
        lo_found = 1'b1;
        lo_idx   = IW'(c);
      end
    end
  end

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign sel_idx = lo_idx;
`else
  logic [IW-1:0] rr_ptr;
  logic          hi_found;
  logic [IW-1:0] hi_idx;

  // Requesters at or above the pointer win first; if none, fall back to the
  // lowest requester below it, which gives the wrapped rotation order.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!hi_found && bus.req[c] && (IW'(c) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_idx   = IW'(c);
      end
    end
  end

  assign sel_idx = hi_found ? hi_idx : lo_idx;

  // Pointer holds the channel that has top priority next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      if (sel_idx == IW'(NCH - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= sel_idx + IW'(1);
      end
    end
  end
`endif

  // Grant is suppressed while reset is high so nothing is accepted then.
  assign accept  = lo_found & ~rst;
  assign bus.gnt = accept ? (NCH'(1) << sel_idx) : '0;

  // Command stage: strobes drop on non-accept cycles, address/data hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ce      <= 1'b0;
      cmd_rd      <= 1'b0;
      cmd_wr      <= 1'b0;
      cmd_addr    <= '0;
      cmd_data_wr <= '0;
    end else if (accept) begin
      cmd_ce      <= 1'b1;
      cmd_rd      <= ~bus.wr[sel_idx];
      cmd_wr      <= bus.wr[sel_idx];
      cmd_addr    <= bus.addr[int'(sel_idx) * AW +: AW];
      cmd_data_wr <= bus.data_wr[int'(sel_idx) * DW +: DW];
    end else begin
      cmd_ce      <= 1'b0;
      cmd_rd      <= 1'b0;
      cmd_wr      <= 1'b0;
    end
  end

  assign bus.ram_ce      = cmd_ce;
  assign bus.ram_rd      = cmd_rd;
  assign bus.ram_wr      = cmd_wr;
  assign bus.ram_addr    = cmd_addr;
  assign bus.ram_data_wr = cmd_data_wr;

  // Read tags: stage 1 lines up with the RAM command, stage 2 with the RAM
  // read data. Writes travel as invalid slots so ordering stays trivial.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag1_v   <= 1'b0;
      tag1_idx <= '0;
      tag2_v   <= 1'b0;
      tag2_idx <= '0;
    end else begin
      tag1_v   <= accept & ~bus.wr[sel_idx];
      tag1_idx <= sel_idx;
      tag2_v   <= tag1_v;
      tag2_idx <= tag1_idx;
    end
  end

  assign bus.rvalid  = tag2_v ? (NCH'(1) << tag2_idx) : '0;
  assign bus.data_rd = tag2_v ? bus.ram_data_rd : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_port_arbiter_if #(.NCH(3), .AW(32), .DW(32)) bus ();

  ram_port_arbiter #(.NCH(3), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Synchronous single-port RAM model, read data one cycle after sampling.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ram_q = '0;
  assign bus.ram_data_rd = ram_q;

  initial begin
    mem[32'h10] = 32'h11;
    mem[32'h20] = 32'h22;
  end

  always @(posedge clk) begin
    if (bus.ram_ce && bus.ram_rd)
      ram_q <= mem.exists(bus.ram_addr) ? mem[bus.ram_addr] : 32'h0;
    if (bus.ram_ce && bus.ram_wr)
      mem[bus.ram_addr] = bus.ram_data_wr;
  end

  typedef struct {
    logic [2:0]  ch;
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [2:0] gnt_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: grant expectations pop every driven cycle, read expectations
  // pop whenever the DUT raises a return strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt_q.size() > 0) begin
        logic [2:0] g;
        g = gnt_q.pop_front();
        check("gnt", 64'(bus.gnt), 64'(g));
      end
      if (bus.rvalid != 3'b000) begin
        if (rd_q.size() == 0) begin
          check("unexpected_rvalid", 64'(bus.rvalid), 64'(0));
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rvalid", 64'(bus.rvalid), 64'(e.ch));
          check("data_rd", 64'(bus.data_rd), 64'(e.data));
          check("rd_latency_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        check("data_rd_idle", 64'(bus.data_rd), 64'(0));
      end
    end
  end

  // Called at posedge+1; drives one cycle of requests and returns at the
  // next posedge+1.
  task automatic drive(input logic [2:0] req, input logic [2:0] wr,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] d,
                       input logic [2:0] exp_gnt);
    bus.req     = req;
    bus.wr      = wr;
    bus.addr    = {a2, a1, a0};
    bus.data_wr = {d, d, d};
    gnt_q.push_back(exp_gnt);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(3'b000, 3'b000, 0, 0, 0, 0, 3'b000);
  endtask

  logic [2:0] fair_exp [6];

  initial begin
`ifdef RAM_ARB_FIXED_PRIO_EN
    fair_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    bus.req     = 3'b111;
    bus.wr      = 3'b000;
    bus.addr    = '0;
    bus.data_wr = '0;

    // Reset with all channels requesting
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 64'(bus.gnt), 0);
    check("rst_ram_ce", 64'(bus.ram_ce), 0);
    check("rst_ram_rd", 64'(bus.ram_rd), 0);
    check("rst_ram_wr", 64'(bus.ram_wr), 0);
    check("rst_ram_addr", 64'(bus.ram_addr), 0);
    check("rst_ram_data_wr", 64'(bus.ram_data_wr), 0);
    check("rst_rvalid", 64'(bus.rvalid), 0);
    check("rst_data_rd", 64'(bus.data_rd), 0);
    rst = 1'b0;

    // Fairness: all three writing for six cycles
    for (int i = 0; i < 6; i++)
      drive(3'b111, 3'b111, 32'h100, 32'h104, 32'h108, 32'h1000 + i, fair_exp[i]);

    // Idle after the last grant, then wrap-around from ch2 to ch0
    drive(3'b000, 3'b000, 0, 0, 0, 0, 3'b000);
    check("idle_ram_ce", 64'(bus.ram_ce), 0);
    check("idle_ram_rd", 64'(bus.ram_rd), 0);
    check("idle_ram_wr", 64'(bus.ram_wr), 0);
    idle(2);
    drive(3'b101, 3'b101, 32'h80, 0, 32'h88, 32'hA5A5A5A5, 3'b001);
    drive(3'b100, 3'b100, 32'h80, 0, 32'h88, 32'hA5A5A5A5, 3'b100);

    // ch1 write then read-back of the same address
    drive(3'b010, 3'b010, 0, 32'h40, 0, 32'hDEADBEEF, 3'b010);
    check("wr_cmd_ce", 64'(bus.ram_ce), 1);
    check("wr_cmd_wr", 64'(bus.ram_wr), 1);
    check("wr_cmd_rd", 64'(bus.ram_rd), 0);
    check("wr_cmd_addr", 64'(bus.ram_addr), 64'h40);
    check("wr_cmd_data", 64'(bus.ram_data_wr), 64'hDEADBEEF);
    rd_q.push_back('{3'b010, 32'hDEADBEEF, cyc + 2});
    drive(3'b010, 3'b000, 0, 32'h40, 0, 32'h0, 3'b010);
    check("rd_cmd_rd", 64'(bus.ram_rd), 1);
    check("rd_cmd_wr", 64'(bus.ram_wr), 0);
    check("rd_cmd_addr", 64'(bus.ram_addr), 64'h40);

    // Pipelined reads from ch0 then ch2
    rd_q.push_back('{3'b001, 32'h11, cyc + 2});
    drive(3'b001, 3'b000, 32'h10, 0, 0, 0, 3'b001);
    rd_q.push_back('{3'b100, 32'h22, cyc + 2});
    drive(3'b100, 3'b000, 0, 0, 32'h20, 0, 3'b100);
    idle(3);

    // Contention after ch2: ch1 first, then ch2
    rd_q.push_back('{3'b010, 32'hDEADBEEF, cyc + 2});
    drive(3'b110, 3'b000, 0, 32'h40, 32'h88, 0, 3'b010);
    rd_q.push_back('{3'b100, 32'hA5A5A5A5, cyc + 2});
    drive(3'b100, 3'b000, 0, 32'h40, 32'h88, 0, 3'b100);
    idle(3);

    // Reset pulse while a ch0 read is in flight: it must never return
    drive(3'b001, 3'b000, 32'h10, 0, 0, 0, 3'b001);
    rst = 1'b1;
    bus.req = 3'b000;
    #2;
    rst = 1'b0;
    gnt_q.push_back(3'b000);
    @(posedge clk);
    #1;
    check("post_rst_ram_ce", 64'(bus.ram_ce), 0);
    idle(4);

    // Recovery read after reset
    rd_q.push_back('{3'b010, 32'hDEADBEEF, cyc + 2});
    drive(3'b010, 3'b000, 0, 32'h40, 0, 0, 3'b010);
    idle(4);

    check("rd_queue_drained", 64'(rd_q.size()), 0);
    check("gnt_queue_drained", 64'(gnt_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
